// File: rtl/spdif_encoder.sv
// spdif_encoder: IEC 60958 consumer S/PDIF transmitter.
//
// Takes stereo PCM pairs through a one-deep holding register and emits
// 192-frame blocks of biphase-mark coded subframes on spdif_out.
//
// Ports:
//   clk        system clock
//   resetb     asynchronous active-low reset
//   en         encoder enable; low aborts and returns to the idle state
//   s_valid    sample pair valid
//   s_ready    holding register empty (always 1 while en=0)
//   s_left     left sample, two's complement
//   s_right    right sample, two's complement
//   cs_word    channel-status bits 0..31 (bits 32..191 are sent as 0)
//   spdif_out  registered BMC output, changes only on UI ticks
//   underrun   one-clock pulse when a frame starts with no sample waiting
//   frame_idx  frame number within the block, 0..191
module spdif_encoder #(
  parameter int SAMPLE_W = 24,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                en,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic [31:0]         cs_word,
  output logic                spdif_out,
  output logic                underrun,
  output logic [7:0]          frame_idx
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Preambles as sent after a low line level, UI 0 in the MSB.
  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [5:0]          ui_q, ui_d;        // UI about to be emitted, 0..63
  logic                sub_q, sub_d;      // 0 = left, 1 = right subframe
  logic [7:0]          frame_q, frame_d;
  logic                out_q, out_d;
  logic                ref_q, ref_d;      // line level just before the preamble
  logic                ur_q, ur_d;
  logic                ready_q, ready_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;
  logic [31:0]         hold_cs_q, hold_cs_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [SAMPLE_W-1:0] right_q, right_d;
  logic                v_q, v_d;
  logic [31:0]         cs_q, cs_d;

  logic        tick;
  logic        xfer;
  logic        load;
  logic [4:0]  slot;
  logic [4:0]  pidx;
  logic [7:0]  pre;
  logic        c_bit;
  logic        parity;
  logic [23:0] smp24;
  logic [27:0] payload;
  logic        next_level;

  assign tick = en && (div_q == DIV_W'(CLK_DIV - 1));
  assign xfer = s_valid && ready_q;
  assign load = tick && (ui_q == 6'd0) && !sub_q;
  assign slot = ui_q[5:1];
  assign pidx = slot - 5'd4;

  // Payload of slots 4..31 for the subframe currently on the wire.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a missed path infers a latch.
    smp24 = '0;
    smp24[23 -: SAMPLE_W] = sub_q ? right_q : left_q;
    c_bit   = (frame_q < 8'd32) ? cs_q[frame_q[4:0]] : 1'b0;
    parity  = ^smp24 ^ v_q ^ c_bit;
    payload = {parity, c_bit, 1'b0, v_q, smp24};
    pre     = sub_q ? PRE_W : ((frame_q == 8'd0) ? PRE_B : PRE_M);
  end

  // Line level for the UI being emitted on this tick.
  always_comb begin
    next_level = out_q;
    if (ui_q < 6'd8) begin
      // UI 0 references the live level; later preamble UIs reuse the
      // level captured at UI 0.
      next_level = pre[3'd7 - ui_q[2:0]] ^ ((ui_q == 6'd0) ? out_q : ref_q);
    end else if (!ui_q[0]) begin
      next_level = ~out_q;
    end else begin
      next_level = out_q ^ payload[pidx];
    end
  end

  always_comb begin
    div_d       = div_q;
    ui_d        = ui_q;
    sub_d       = sub_q;
    frame_d     = frame_q;
    out_d       = out_q;
    ref_d       = ref_q;
    ur_d        = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_cs_d   = hold_cs_q;
    left_d      = left_q;
    right_d     = right_q;
    v_d         = v_q;
    cs_d        = cs_q;

    if (!en) begin
      div_d   = '0;
      ui_d    = '0;
      sub_d   = 1'b0;
      frame_d = '0;
      out_d   = 1'b0;
      ref_d   = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        out_d = next_level;
        if (ui_q == 6'd0) ref_d = out_q;
        ui_d = ui_q + 6'd1;
        if (ui_q == 6'd63) begin
          sub_d = ~sub_q;
          if (sub_q) frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
        end
      end
    end

    if (load) begin
      if (hold_full_q) begin
        left_d  = hold_l_q;
        right_d = hold_r_q;
        v_d     = 1'b0;
      end else begin
        left_d  = '0;
        right_d = '0;
        v_d     = 1'b1;
        ur_d    = 1'b1;
      end
      if (frame_q == 8'd0) cs_d = hold_cs_q;
      hold_full_d = 1'b0;
    end

    // A transfer on the load edge refills the register the frame just drained.
    if (xfer) begin
      hold_l_d    = s_left;
      hold_r_d    = s_right;
      hold_cs_d   = cs_word;
      hold_full_d = 1'b1;
    end

    ready_d = en ? ~hold_full_d : 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      div_q       <= '0;
      ui_q        <= '0;
      sub_q       <= 1'b0;
      frame_q     <= '0;
      out_q       <= 1'b0;
      ref_q       <= 1'b0;
      ur_q        <= 1'b0;
      ready_q     <= 1'b0;
      hold_full_q <= 1'b0;
      // NOTE: the sample registers are reset too; they are few and a known
      // value keeps the parity logic free of X after reset.
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_cs_q   <= '0;
      left_q      <= '0;
      right_q     <= '0;
      v_q         <= 1'b0;
      cs_q        <= '0;
    end else begin
      div_q       <= div_d;
      ui_q        <= ui_d;
      sub_q       <= sub_d;
      frame_q     <= frame_d;
      out_q       <= out_d;
      ref_q       <= ref_d;
      ur_q        <= ur_d;
      ready_q     <= ready_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_cs_q   <= hold_cs_d;
      left_q      <= left_d;
      right_q     <= right_d;
      v_q         <= v_d;
      cs_q        <= cs_d;
    end
  end

  assign s_ready   = ready_q;
  assign spdif_out = out_q;
  assign underrun  = ur_q;
  assign frame_idx = frame_q;

endmodule

// File: tb/tb_spdif_encoder.sv
// tb_spdif_encoder: drives two encoders (CLK_DIV=1/SAMPLE_W=24 and
// CLK_DIV=4/SAMPLE_W=16) from shared sample inputs and compares every
// output on every cycle with a frame-level reference model.
module tb_spdif_encoder;

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  logic        clk = 1'b0;
  logic        resetb;
  logic [1:0]  en;
  logic        s_valid;
  logic [23:0] s_left;
  logic [23:0] s_right;
  logic [31:0] cs_word;
  logic [1:0]  so_out;
  logic [1:0]  so_rdy;
  logic [1:0]  so_ur;
  logic [7:0]  so_fi [2];

  always #5 clk = ~clk;

  spdif_encoder #(.SAMPLE_W(24), .CLK_DIV(1)) dut_a (
    .clk(clk), .resetb(resetb), .en(en[0]), .s_valid(s_valid),
    .s_ready(so_rdy[0]), .s_left(s_left), .s_right(s_right),
    .cs_word(cs_word), .spdif_out(so_out[0]), .underrun(so_ur[0]),
    .frame_idx(so_fi[0])
  );

  spdif_encoder #(.SAMPLE_W(16), .CLK_DIV(4)) dut_b (
    .clk(clk), .resetb(resetb), .en(en[1]), .s_valid(s_valid),
    .s_ready(so_rdy[1]), .s_left(s_left[23:8]), .s_right(s_right[23:8]),
    .cs_word(cs_word), .spdif_out(so_out[1]), .underrun(so_ur[1]),
    .frame_idx(so_fi[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, one slot per DUT.
  int          div_of [2] = '{1, 4};
  int          m_n    [2];          // clocks since enable
  int          m_fr   [2];
  logic        m_out  [2];
  logic        m_ur   [2];
  logic        m_rdy  [2];
  logic        m_have [2];
  logic [23:0] m_hl   [2];
  logic [23:0] m_hr   [2];
  logic [31:0] m_lcs  [2];          // cs_word of the latest transfer
  logic [31:0] m_cs   [2];          // cs_word in force for this block
  logic [63:0] m_lv   [2];          // expected UI levels, left subframe
  logic [63:0] m_rv   [2];          // expected UI levels, right subframe
  int          ur_seen[2];
  logic [1:0]  last_xf;

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  // Whole subframe as 64 line levels, built straight from the slot layout.
  function automatic logic [63:0] bmc_subframe(input logic [7:0] pre,
      input logic [23:0] smp, input logic v, input logic c, input logic start);
    logic [63:0] ui;
    logic [27:0] data;
    logic        lvl;
    data     = {1'b0, c, 1'b0, v, smp};
    data[27] = ($countones(data[26:0]) % 2) == 1;
    for (int i = 0; i < 8; i++) ui[i] = pre[7-i] ^ start;
    lvl = ui[7];
    for (int s = 0; s < 28; s++) begin
      lvl = ~lvl;
      ui[8+2*s] = lvl;
      if (data[s]) lvl = ~lvl;
      ui[9+2*s] = lvl;
    end
    return ui;
  endfunction

  task automatic model_edge(input int d, input logic rb, input logic e, input logic xf);
    int          p;
    logic [23:0] l, r;
    logic        v, c;
    m_ur[d] = 1'b0;
    if (!rb) begin
      m_n[d] = 0; m_fr[d] = 0; m_out[d] = 1'b0; m_rdy[d] = 1'b0;
      m_have[d] = 1'b0; m_hl[d] = '0; m_hr[d] = '0; m_lcs[d] = '0; m_cs[d] = '0;
      return;
    end
    if (!e) begin
      m_n[d] = 0; m_fr[d] = 0; m_out[d] = 1'b0;
    end else begin
      m_n[d]++;
      if (m_n[d] % div_of[d] == 0) begin
        p = (m_n[d] / div_of[d] - 1) % 128;
        if (p == 0) begin
          if (m_have[d]) begin
            l = m_hl[d]; r = m_hr[d]; v = 1'b0;
          end else begin
            l = '0; r = '0; v = 1'b1; m_ur[d] = 1'b1;
          end
          m_have[d] = 1'b0;
          if (m_fr[d] == 0) m_cs[d] = m_lcs[d];
          c = (m_fr[d] < 32) ? m_cs[d][m_fr[d]] : 1'b0;
          m_lv[d] = bmc_subframe((m_fr[d] == 0) ? PRE_B : PRE_M, l, v, c, m_out[d]);
          m_rv[d] = bmc_subframe(PRE_W, r, v, c, m_lv[d][63]);
        end
        m_out[d] = (p < 64) ? m_lv[d][p] : m_rv[d][p-64];
        if (p == 127) m_fr[d] = (m_fr[d] + 1) % 192;
      end
    end
    if (xf) begin
      m_hl[d]   = (d == 0) ? s_left  : {s_left[23:8], 8'h00};
      m_hr[d]   = (d == 0) ? s_right : {s_right[23:8], 8'h00};
      m_lcs[d]  = cs_word;
      m_have[d] = 1'b1;
    end
    m_rdy[d] = e ? !m_have[d] : 1'b1;
  endtask

  // One clock: note what the edge will see, advance, then compare at +1.
  task automatic step();
    logic       rb;
    logic [1:0] e;
    rb = resetb;
    e  = en;
    for (int d = 0; d < 2; d++) last_xf[d] = rb && s_valid && (m_rdy[d] === 1'b1);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      model_edge(d, rb, e[d], last_xf[d]);
      check("spdif_out", d, 32'(so_out[d]), 32'(m_out[d]));
      check("underrun",  d, 32'(so_ur[d]),  32'(m_ur[d]));
      check("s_ready",   d, 32'(so_rdy[d]), 32'(m_rdy[d]));
      check("frame_idx", d, 32'(so_fi[d]),  32'(m_fr[d]));
      if (so_ur[d] === 1'b1) ur_seen[d]++;
    end
  endtask

  task automatic rand_pair();
    s_left  = 24'($urandom);
    s_right = 24'($urandom);
  endtask

  initial begin
    resetb  = 1'b0;
    en      = 2'b00;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    cs_word = '0;
    ur_seen = '{0, 0};

    // Reset with random activity on every input.
    repeat (6) begin
      en      = 2'($urandom);
      s_valid = 1'($urandom);
      rand_pair();
      cs_word = $urandom;
      step();
    end
    en      = 2'b10;
    s_valid = 1'b0;
    resetb  = 1'b1;
    repeat (8) step();
    en = 2'b00;
    step();

    // Known first frame, then 193 more pairs back-to-back on dut_a.
    s_valid = 1'b1;
    s_left  = 24'h000001;
    s_right = 24'h800000;
    cs_word = 32'h0000_0004;
    step();
    rand_pair();
    en[0] = 1'b1;
    ur_seen = '{0, 0};
    while (m_n[0] < 194 * 128) begin
      step();
      if (last_xf[0]) rand_pair();
    end
    check("no_underrun_streaming", 0, 32'(ur_seen[0]), 32'd0);

    // Starve across one frame boundary.
    s_valid    = 1'b0;
    ur_seen[0] = 0;
    repeat (200) step();
    check("underrun_pulses", 0, 32'(ur_seen[0]), 32'd1);

    // Random back-pressure and channel-status churn.
    repeat (384) begin
      s_valid = ($urandom_range(0, 3) != 0);
      rand_pair();
      cs_word = $urandom;
      step();
    end

    // dut_b: run to slot 15 of frame 1's left subframe, then abort.
    en      = 2'b00;
    s_valid = 1'b0;
    step();
    en[1] = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (m_fr[1] == 1 && m_n[1] % 4 == 0 && ((m_n[1] / 4 - 1) % 128) == 30) break;
      s_valid = ($urandom_range(0, 3) != 0);
      rand_pair();
      step();
    end
    check("abort_frame_idx", 1, 32'(so_fi[1]), 32'd1);
    en[1]   = 1'b0;
    s_valid = 1'b0;
    step();
    check("abort_out_low", 1, 32'(so_out[1]), 32'd0);
    repeat (3) step();

    // Restart: first tick four clocks later, opening with B in frame 0.
    en[1] = 1'b1;
    repeat (3) step();
    check("pre_first_tick", 1, 32'(so_out[1]), 32'd0);
    step();
    check("first_tick_b_ui0", 1, 32'(so_out[1]), 32'd1);
    check("restart_frame_idx", 1, 32'(so_fi[1]), 32'd0);
    repeat (2 * 512 + 16) begin
      s_valid = ($urandom_range(0, 4) != 0);
      rand_pair();
      cs_word = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spdif_encoder.md
Name: spdif_encoder

Overview:
- S/PDIF (IEC 60958 consumer) transmitter: the transmit counterpart of the on-chip S/PDIF receiver.
- Accepts stereo PCM sample pairs over a valid/ready handshake.
- Builds 32-slot subframes with preambles, V/U/C bits and parity, and emits a biphase-mark (BMC) serial stream on a single output pin.
- Sits between the audio datapath (sample source) and a dedicated output pad.

Parameters:
- SAMPLE_W, 24, audio sample width, 16..24. MSB-aligned to slot 27; unused low slots are sent as 0.
- CLK_DIV, 2, clk cycles per BMC unit interval (UI = half bit cell), >=1. Frame rate = f_clk/(CLK_DIV*128).

Ports:
- clk  input  1  system clock
- resetb  input  1  asynchronous active-low reset
- en  input  1  encoder enable
- s_valid  input  1  sample pair valid
- s_ready  output  1  holding register empty, accepts pair
- s_left  input  SAMPLE_W  left sample, two's complement
- s_right  input  SAMPLE_W  right sample, two's complement
- cs_word  input  32  channel-status bits 0..31; bits 32..191 are sent as 0
- spdif_out  output  1  BMC serial output, registered
- underrun  output  1  one-clock pulse when a frame starts with no sample available
- frame_idx  output  8  current frame number within the block, 0..191

Behaviour:
- Reset values: spdif_out=0, s_ready=0, underrun=0, frame_idx=0. Holding register is empty. Divider, UI, slot and frame counters are all 0.
- en=0: same state as reset, except s_ready=1 and the holding register keeps its contents. Dropping en mid-frame aborts immediately; the next en rise restarts at frame 0, B preamble.
- UI tick: the divider counts 0..CLK_DIV-1 and ticks at CLK_DIV-1. The first tick occurs CLK_DIV clocks after en rises. spdif_out updates only on ticks.
- Handshake: a transfer occurs when s_valid && s_ready on a rising edge and loads the one-deep holding register. s_ready = holding empty. s_left, s_right and cs_word are sampled only on a transfer.
- Frame load: on the tick that emits UI 0 of the left subframe, the holding register moves to the shift registers, and the holding register empties the following cycle.
- Simultaneous frame load and handshake on a full holding register: the old pair goes to the frame and the new pair is stored, so the register stays full.
- Underrun: at frame load with the holding register empty, underrun pulses once, both subframes carry sample 0 with V=1, and the encoder keeps running. A handshake in that same cycle is stored for the next frame.
- cs_word is latched at frame 0 load from the latest transfer.
- Subframe slot layout (one slot = 2 UI):
  - 0-3: preamble
  - 4-27: sample LSB-first, MSB at 27
  - 28: V (0 normally, 1 on underrun)
  - 29: U = 0
  - 30: C = channel-status bit frame_idx (left and right carry the same bit)
  - 31: P, chosen so slots 4..31 hold an even number of ones
- Preambles (8 UI, written for a previous line level of 0; XOR every UI with the last output level when that level is 1):
  - B = 11101000: left subframe, frame 0
  - M = 11100010: left subframe, other frames
  - W = 11100100: right subframe
- BMC data: every slot 4..31 inverts the level at its first UI. A 1 inverts again at its second UI; a 0 holds.
- frame_idx increments after each right subframe and wraps 191 -> 0. The next frame after the wrap uses B.
- Even parity guarantees each subframe ends at the level its preamble ended on; a mismatch is a bug.

Test Plan:
- Reset: hold resetb=0 with random inputs -> spdif_out=0, s_ready=0, underrun=0, frame_idx=0. After release with en=1 -> s_ready=1.
- Single frame (CLK_DIV=1, SAMPLE_W=24): send L=0x000001, R=0x800000 before en -> UI stream decodes to B / L slot4=1 / P=1, then W / R slot27=1 / P=1, with V=0 and no underrun.
- Block structure: stream 193 pairs back-to-back -> preamble B at frames 0 and 192, M at frames 1..191, W on every right subframe. frame_idx wraps 191->0.
- Channel status: cs_word=0x00000004 -> C=1 only in frame 2 (both subframes) of every block; all other frames C=0.
- Underrun / back-pressure: hold s_valid=0 over a frame boundary -> underrun pulses once, sample 0 with V=1. With s_valid held high, s_ready deasserts while the register is full and exactly one pair is accepted per frame.
- Abort and CLK_DIV=4: drop en at slot 15 of a left subframe -> spdif_out=0 the next cycle. Re-enable -> first tick after 4 clocks, then B preamble and frame_idx=0. Every UI lasts 4 clocks.
